// File: rtl/ad9866_pkg.sv
// Shared constants, FSM state type and SPI word builders for the AD9866 register scheduler.
package ad9866_pkg;

  localparam logic [7:0] AD9866_ADDR_RXGAIN = 8'h0a;
  localparam logic [7:0] AD9866_ADDR_TXGAIN = 8'h11;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } ad9866_ctrl_state_t;

  function automatic logic [15:0] host_word(input logic rnw, input logic [4:0] addr,
                                            input logic [7:0] data);
    return {rnw, 2'b00, addr, data};
  endfunction

  function automatic logic [15:0] rxgain_word(input logic [5:0] gain);
    return {AD9866_ADDR_RXGAIN, 2'b01, gain};
  endfunction

  function automatic logic [15:0] txgain_word(input logic [3:0] gain);
    return {AD9866_ADDR_TXGAIN, 4'h0, gain};
  endfunction

endpackage

// File: rtl/ad9866_ctrl.sv
// AD9866 SPI register-write scheduler: host port, RX gain and TX gain share one shifter.
// Build with AD9866_READBACK_EN defined to enable host register reads.
module ad9866_ctrl
  import ad9866_pkg::*;
#(
  parameter int STARTUP_CYCLES = 1024,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  rxgain,
  input  logic [3:0]  txgain,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_rnw,
  input  logic [4:0]  host_addr,
  input  logic [7:0]  host_data,
  output logic        spi_start,
  output logic [15:0] spi_word,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rdata,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        init_done,
  output logic        spi_err
);

  // One counter serves the startup hold-off, the busy timeout and the gap.
  localparam int CNT_W = $clog2(STARTUP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  ad9866_ctrl_state_t state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [5:0]         rx_sent_q;
  logic [3:0]         tx_sent_q;
  logic               rx_pend_q;
  logic               tx_pend_q;
  logic               cur_read_q;
  logic               spi_start_q;
  logic [15:0]        spi_word_q;
  logic               init_done_q;
  logic               spi_err_q;
  logic               host_rnw_s;

`ifdef AD9866_READBACK_EN
  assign host_rnw_s = host_rnw;
`else
  assign host_rnw_s = 1'b0;
`endif

  assign host_ready = (state_q == ST_IDLE) & init_done_q;
  assign spi_start  = spi_start_q;
  assign spi_word   = spi_word_q;
  assign init_done  = init_done_q;
  assign spi_err    = spi_err_q;

  // Scheduler FSM, gain shadows/pend flags and registered SPI outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STARTUP;
      cnt_q       <= '0;
      rx_sent_q   <= 6'd0;
      tx_sent_q   <= 4'd0;
      rx_pend_q   <= 1'b0;
      tx_pend_q   <= 1'b0;
      cur_read_q  <= 1'b0;
      spi_start_q <= 1'b0;
      spi_word_q  <= 16'h0000;
      init_done_q <= 1'b0;
      spi_err_q   <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      // Later assignments below (issue clear, startup force) override these sets.
      if (rxgain != rx_sent_q) rx_pend_q <= 1'b1;
      if (txgain != tx_sent_q) tx_pend_q <= 1'b1;
      case (state_q)
        ST_STARTUP: begin
          if (cnt_q == STARTUP_LAST) begin
            init_done_q <= 1'b1;
            rx_pend_q   <= 1'b1;
            tx_pend_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          cnt_q <= '0;
          if (host_valid && host_ready) begin
            spi_word_q  <= host_word(host_rnw_s, host_addr, host_data);
            cur_read_q  <= host_rnw_s;
            spi_start_q <= 1'b1;
            state_q     <= ST_WAIT_BUSY;
          end else if (rx_pend_q) begin
            spi_word_q  <= rxgain_word(rxgain);
            rx_sent_q   <= rxgain;
            rx_pend_q   <= 1'b0;
            cur_read_q  <= 1'b0;
            spi_start_q <= 1'b1;
            state_q     <= ST_WAIT_BUSY;
          end else if (tx_pend_q) begin
            spi_word_q  <= txgain_word(txgain);
            tx_sent_q   <= txgain;
            tx_pend_q   <= 1'b0;
            cur_read_q  <= 1'b0;
            spi_start_q <= 1'b1;
            state_q     <= ST_WAIT_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          if (spi_busy) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q == TMO_LAST) begin
            spi_err_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!spi_busy) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_STARTUP;
        end
      endcase
    end
  end

`ifdef AD9866_READBACK_EN
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  // Capture the shifted-back byte as a host read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else if ((state_q == ST_WAIT_DONE) && !spi_busy && cur_read_q) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= spi_rdata;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  logic unused_s;
  assign unused_s = ^{host_rnw, spi_rdata, cur_read_q};
  assign rd_valid = 1'b0;
  assign rd_data  = 8'h00;
`endif

endmodule

// File: tb/tb_ad9866_ctrl.sv
// Self-checking bench for ad9866_ctrl: vector table plus scoreboard of expected SPI words and read bytes.
module tb_ad9866_ctrl;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  rxgain = 6'h15;
  logic [3:0]  txgain = 4'h3;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_rnw = 1'b0;
  logic [4:0]  host_addr = 5'h00;
  logic [7:0]  host_data = 8'h00;
  logic        spi_start;
  logic [15:0] spi_word;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_rdata = 8'h00;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        init_done;
  logic        spi_err;

  ad9866_ctrl dut (
    .clk(clk), .reset(reset), .rxgain(rxgain), .txgain(txgain),
    .host_valid(host_valid), .host_ready(host_ready), .host_rnw(host_rnw),
    .host_addr(host_addr), .host_data(host_data), .spi_start(spi_start),
    .spi_word(spi_word), .spi_busy(spi_busy), .spi_rdata(spi_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .init_done(init_done), .spi_err(spi_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  bit have_fall = 1'b0;
  bit shifter_en = 1'b1;
  int busy_len = 3;
  int busy_rem = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_q[$];

  typedef struct {
    int          kind;   // 0 host write, 1 RX gain change, 2 TX gain change
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [5:0]  rx;
    logic [3:0]  tx;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model plus scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  r;
    if (reset) begin
      spi_busy = 1'b0;
      busy_rem = 0;
    end else begin
      if (spi_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: actual=%0h required=none (cycle %0d)", spi_word, cyc);
        end else begin
          w = exp_q.pop_front();
          chk("spi_word", spi_word === w, spi_word, w);
        end
        if (have_fall) chk("gap_spacing", (cyc - fall_cyc) >= GAP + 1, cyc - fall_cyc, GAP + 1);
        if (shifter_en) begin
          spi_busy = 1'b1;
          busy_rem = busy_len;
        end
      end else if (busy_rem > 1) begin
        busy_rem--;
      end else if (spi_busy) begin
        spi_busy  = 1'b0;
        busy_rem  = 0;
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rd_valid: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          r = rd_q.pop_front();
          chk("rd_data", rd_data === r, rd_data, r);
          chk("rd_align", cyc == fall_cyc + 1, cyc, fall_cyc + 1);
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && host_ready && !spi_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", name}, n < budget, n, budget);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({"ready_", name}, n < 200, n, 200);
  endtask

  task automatic host_req(input logic rnw, input logic [4:0] addr, input logic [7:0] data,
                          input logic [15:0] exp);
    wait_ready("host");
    host_valid = 1'b1;
    host_rnw   = rnw;
    host_addr  = addr;
    host_data  = data;
    exp_q.push_back(exp);
    @(negedge clk);
    host_valid = 1'b0;
    chk("host_latency", spi_start === 1'b1, spi_start, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_host_ready"}, host_ready === 1'b0, host_ready, 0);
    chk({name, "_spi_start"}, spi_start === 1'b0, spi_start, 0);
    chk({name, "_spi_word"}, spi_word === 16'h0000, spi_word, 0);
    chk({name, "_rd_valid"}, rd_valid === 1'b0, rd_valid, 0);
    chk({name, "_rd_data"}, rd_data === 8'h00, rd_data, 0);
    chk({name, "_init_done"}, init_done === 1'b0, init_done, 0);
    chk({name, "_spi_err"}, spi_err === 1'b0, spi_err, 0);
  endtask

  initial begin
    vecs[0] = '{0, 5'h01, 8'h00, 6'h00, 4'h0, 16'h0100};
    vecs[1] = '{0, 5'h1f, 8'hff, 6'h00, 4'h0, 16'h1fff};
    vecs[2] = '{0, 5'h0a, 8'ha5, 6'h00, 4'h0, 16'h0aa5};
    vecs[3] = '{1, 5'h00, 8'h00, 6'h3f, 4'h0, 16'h0a7f};
    vecs[4] = '{1, 5'h00, 8'h00, 6'h00, 4'h0, 16'h0a40};
    vecs[5] = '{2, 5'h00, 8'h00, 6'h00, 4'hf, 16'h110f};
    vecs[6] = '{2, 5'h00, 8'h00, 6'h00, 4'h8, 16'h1108};

    // Reset state and startup programming of both gains.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    exp_q.push_back(16'h0a55);
    exp_q.push_back(16'h1103);
    repeat (1023) @(posedge clk);
    @(negedge clk);
    chk("init_done_early", init_done === 1'b0, init_done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("init_done_1024", init_done === 1'b1, init_done, 1);
    drain("startup", 200);

    // Table of single requests, each with its start latency.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].kind == 0) begin
        host_req(1'b0, vecs[i].addr, vecs[i].data, vecs[i].exp);
      end else begin
        if (vecs[i].kind == 1) rxgain = vecs[i].rx;
        else txgain = vecs[i].tx;
        exp_q.push_back(vecs[i].exp);
        @(negedge clk);
        chk("gain_latency_n1", spi_start === 1'b0, spi_start, 0);
        @(negedge clk);
        chk("gain_latency_n2", spi_start === 1'b1, spi_start, 1);
      end
      drain("vec", 200);
    end

    // Host write and RX gain change in the same cycle: host wins.
    wait_ready("hostrx");
    host_valid = 1'b1;
    host_rnw   = 1'b0;
    host_addr  = 5'h08;
    host_data  = 8'h4b;
    rxgain     = 6'h11;
    exp_q.push_back(16'h084b);
    exp_q.push_back(16'h0a51);
    @(negedge clk);
    host_valid = 1'b0;
    drain("hostrx", 200);

    // RX gain changes twice during its own transfer: only the latest is resent.
    busy_len = 12;
    rxgain = 6'h10;
    exp_q.push_back(16'h0a50);
    repeat (4) @(negedge clk);
    rxgain = 6'h20;
    exp_q.push_back(16'h0a6a);
    repeat (2) @(negedge clk);
    rxgain = 6'h2a;
    drain("rxmulti", 200);
    repeat (40) @(negedge clk);
    chk("rxmulti_no_extra", exp_q.size() == 0, exp_q.size(), 0);
    busy_len = 3;

    // Host read with shifter returning 0x5a.
    spi_rdata = 8'h5a;
`ifdef AD9866_READBACK_EN
    rd_q.push_back(8'h5a);
    host_req(1'b1, 5'h1f, 8'h00, 16'h9f00);
`else
    host_req(1'b1, 5'h1f, 8'h00, 16'h1f00);
`endif
    drain("read", 200);
    chk("read_consumed", rd_q.size() == 0, rd_q.size(), 0);

    // Busy never rises: sticky error on the eighth cycle after start.
    shifter_en = 1'b0;
    host_req(1'b0, 5'h03, 8'h77, 16'h0377);
    repeat (7) @(negedge clk);
    chk("err_before_timeout", spi_err === 1'b0, spi_err, 0);
    @(negedge clk);
    chk("err_at_timeout", spi_err === 1'b1, spi_err, 1);
    shifter_en = 1'b1;
    host_req(1'b0, 5'h04, 8'h22, 16'h0422);
    drain("after_err", 200);
    chk("err_sticky", spi_err === 1'b1, spi_err, 1);

    // Reset while in WAIT_DONE, then both gains resent after the new hold-off.
    busy_len = 20;
    rxgain = 6'h07;
    exp_q.push_back(16'h0a47);
    repeat (7) @(negedge clk);
    chk("mid_busy", spi_busy === 1'b1, spi_busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_len = 3;
    exp_q.push_back(16'h0a47);
    exp_q.push_back(16'h1108);
    repeat (500) @(negedge clk);
    chk("reinit_holdoff", init_done === 1'b0, init_done, 0);
    drain("reinit", 800);
    chk("reinit_done", init_done === 1'b1, init_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
